// File: rtl/control_sequencer.sv
// Hardwired control unit for the single-bus CPU datapath.
// Sequences fetch (T0-T2) and execute (T3-T5) of register-register ALU ops.
module control_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [31:0]      IR,
  input  logic             Mem_ready,
  input  logic             Stop,
  output logic             PCout,
  output logic             Zlowout,
  output logic             MDRout,
  output logic             MARin,
  output logic             Zin,
  output logic             PCin,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             IncPC,
  output logic             Read,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             Rin,
  output logic             Rout,
  output logic [4:0]       alu_op,
  output logic             Run,
  output logic             Illegal,
  output logic             Mem_err,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    IDLE, T0, T1, T2, T3, T4, T5, HALTED
  } state_t;

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0]    TLAST = TW'(MEM_TIMEOUT - 1);
  localparam logic [TW-1:0]    TONE  = TW'(1);
  localparam logic [CNT_W-1:0] CONE  = CNT_W'(1);

  state_t        state;
  logic [TW-1:0] tcnt;
  logic [4:0]    opcode;
  logic          is_alu;
  logic          is_nop;
  logic          is_halt;

  assign opcode  = IR[31:27];
  assign is_alu  = (opcode >= 5'd3) && (opcode <= 5'd11);
  assign is_nop  = (opcode == 5'b11010);
  assign is_halt = (opcode == 5'b11011);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      tcnt        <= '0;
      Mem_err     <= 1'b0;
      instr_count <= '0;
    end else begin
      unique case (state)
        IDLE: state <= T0;
        T0:   state <= T1;
        T1: begin
          if (Mem_ready) begin
            state <= T2;
            tcnt  <= '0;
          end else if (tcnt == TLAST) begin
            state   <= HALTED;
            Mem_err <= 1'b1;
            tcnt    <= '0;
          end else begin
            tcnt <= tcnt + TONE;
          end
        end
        T2: state <= T3;
        T3: begin
          unique case (1'b1)
            is_alu: state <= T4;
            is_halt: begin
              instr_count <= instr_count + CONE;
              state       <= HALTED;
            end
            is_nop: begin
              instr_count <= instr_count + CONE;
              state       <= Stop ? HALTED : T0;
            end
            default: state <= Stop ? HALTED : T0;
          endcase
        end
        T4: state <= T5;
        T5: begin
          instr_count <= instr_count + CONE;
          state       <= Stop ? HALTED : T0;
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

  // Mem_ready gates PCin so the PC only loads once the fetch lands.
  always_comb begin
    PCout   = 1'b0;
    Zlowout = 1'b0;
    MDRout  = 1'b0;
    MARin   = 1'b0;
    Zin     = 1'b0;
    PCin    = 1'b0;
    MDRin   = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    Rin     = 1'b0;
    Rout    = 1'b0;
    alu_op  = 5'd0;
    Run     = 1'b0;
    Illegal = 1'b0;
    unique case (state)
      T0: begin
        Run   = 1'b1;
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      T1: begin
        Run     = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        Zlowout = 1'b1;
        PCin    = Mem_ready;
      end
      T2: begin
        Run    = 1'b1;
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        Run     = 1'b1;
        Grb     = is_alu;
        Rout    = is_alu;
        Yin     = is_alu;
        Illegal = !is_alu && !is_nop && !is_halt;
      end
      T4: begin
        Run    = 1'b1;
        Grc    = 1'b1;
        Rout   = 1'b1;
        Zin    = 1'b1;
        alu_op = opcode;
      end
      T5: begin
        Run     = 1'b1;
        Zlowout = 1'b1;
        Gra     = 1'b1;
        Rin     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized scoreboard bench for control_sequencer.
// Per-instruction cycle traces are queued; a negedge monitor compares.
module tb_control_sequencer;

  localparam int TO = 15;
  localparam int CW = 16;

  localparam int PCOUT = 0, ZLOW = 1, MDROUT = 2, MARIN = 3, ZIN = 4;
  localparam int PCIN = 5, MDRIN = 6, IRIN = 7, YIN = 8, INCPC = 9;
  localparam int READ = 10, GRA = 11, GRB = 12, GRC = 13, RIN = 14;
  localparam int ROUT = 15, RUN = 21, ILL = 22, MERR = 23;

  logic          Clock = 1'b0;
  logic          Reset_n = 1'b0;
  logic [31:0]   IR = '0;
  logic          Mem_ready = 1'b0;
  logic          Stop = 1'b0;
  logic          PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin;
  logic          IRin, Yin, IncPC, Read, Gra, Grb, Grc, Rin, Rout;
  logic [4:0]    alu_op;
  logic          Run, Illegal, Mem_err;
  logic [CW-1:0] instr_count;

  control_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .IR(IR),
    .Mem_ready(Mem_ready), .Stop(Stop),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .IncPC(IncPC), .Read(Read),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .alu_op(alu_op), .Run(Run), .Illegal(Illegal),
    .Mem_err(Mem_err), .instr_count(instr_count)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [23:0]   v;
    logic [CW-1:0] c;
    string         tag;
  } exp_t;

  exp_t          q[$];
  exp_t          e;
  int            tests = 0;
  int            fails = 0;
  logic [CW-1:0] cnt_m = '0;
  logic          merr_m = 1'b0;
  logic [31:0]   ir_next = '0;
  bit            h;

  wire [23:0] act = {Mem_err, Illegal, Run, alu_op, Rout, Rin, Grc,
                     Grb, Gra, Read, IncPC, Yin, IRin, MDRin, PCin,
                     Zin, MARin, MDRout, Zlowout, PCout};

  function automatic logic [23:0] bt(input int i);
    return 24'(1) << i;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string n, input logic [31:0] a,
                       input logic [31:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, x);
    end
  endtask

  always @(negedge Clock) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      check({e.tag, " outputs"}, 32'(act), 32'(e.v));
      check({e.tag, " count"}, 32'(instr_count), 32'(e.c));
      check({e.tag, " bus"},
            32'($countones({PCout, Zlowout, MDRout, Rout}) <= 1), 32'd1);
    end
  end

  task automatic push(input logic [23:0] v, input string tag);
    exp_t x;
    x.v   = v | (merr_m ? bt(MERR) : 24'd0);
    x.c   = cnt_m;
    x.tag = tag;
    q.push_back(x);
  endtask

  task automatic cyc(input logic mr, input logic st, input logic [23:0] v,
                     input string tag);
    @(posedge Clock);
    #1;
    IR        = ir_next;
    Mem_ready = mr;
    Stop      = st;
    push(v, tag);
  endtask

  task automatic release_rst();
    @(posedge Clock);
    #1;
    Reset_n = 1'b1;
    push(24'd0, "idle");
  endtask

  task automatic do_reset();
    @(posedge Clock);
    #1;
    Reset_n = 1'b0;
    cnt_m   = '0;
    merr_m  = 1'b0;
    push(24'd0, "rst");
    release_rst();
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) cyc(rb(), rb(), 24'd0, "halted");
  endtask

  // One instruction as the programmer sees it: fetch, wait, decode, retire.
  task automatic instr(input logic [31:0] ir, input int wt, input logic stop,
                       input bit abort, output bit halted);
    logic [4:0]  op;
    logic [23:0] rv;
    op      = ir[31:27];
    rv      = bt(RUN);
    halted  = 1'b0;
    ir_next = ir;
    cyc(rb(), rb(), rv | bt(PCOUT) | bt(MARIN) | bt(INCPC) | bt(ZIN), "T0");
    if (wt >= TO) begin
      for (int i = 0; i < TO; i++)
        cyc(1'b0, rb(), rv | bt(READ) | bt(MDRIN) | bt(ZLOW), "T1wait");
      merr_m = 1'b1;
      halted = 1'b1;
      return;
    end
    for (int i = 0; i < wt; i++)
      cyc(1'b0, rb(), rv | bt(READ) | bt(MDRIN) | bt(ZLOW), "T1wait");
    cyc(1'b1, rb(), rv | bt(READ) | bt(MDRIN) | bt(ZLOW) | bt(PCIN),
        "T1ready");
    cyc(rb(), rb(), rv | bt(MDROUT) | bt(IRIN), "T2");
    if (op >= 5'd3 && op <= 5'd11) begin
      cyc(rb(), rb(), rv | bt(GRB) | bt(ROUT) | bt(YIN), "T3alu");
      cyc(rb(), stop | rb(),
          rv | bt(GRC) | bt(ROUT) | bt(ZIN) | (24'(op) << 16), "T4");
      if (abort) begin
        @(negedge Clock);
        #2;
        Reset_n = 1'b0;
        #1;
        check("async reset outputs", 32'(act), 32'd0);
        check("async reset count", 32'(instr_count), 32'd0);
        cnt_m  = '0;
        merr_m = 1'b0;
        release_rst();
        return;
      end
      cyc(rb(), stop, rv | bt(ZLOW) | bt(GRA) | bt(RIN), "T5");
      cnt_m++;
      halted = stop;
    end else if (op == 5'b11010) begin
      cyc(rb(), stop, rv, "T3nop");
      cnt_m++;
      halted = stop;
    end else if (op == 5'b11011) begin
      cyc(rb(), rb(), rv, "T3halt");
      cnt_m++;
      halted = 1'b1;
    end else begin
      cyc(rb(), stop, rv | bt(ILL), "T3illegal");
      halted = stop;
    end
  endtask

  function automatic logic [31:0] rand_ir(input logic [4:0] op);
    return {op, 27'($urandom)};
  endfunction

  initial begin
    int          r;
    int          wt;
    logic [4:0]  op;
    #1;
    check("reset outputs", 32'(act), 32'd0);
    check("reset count", 32'(instr_count), 32'd0);
    release_rst();

    instr(32'h28918000, 0, 1'b0, 1'b0, h);
    instr(rand_ir(5'd3), 3, 1'b0, 1'b0, h);
    instr(32'hF8000000, 1, 1'b0, 1'b0, h);
    instr(rand_ir(5'd26), 0, 1'b0, 1'b0, h);
    instr(32'hD8000000, 0, 1'b0, 1'b0, h);
    hold(3);
    do_reset();

    instr(rand_ir(5'd4), TO, 1'b0, 1'b0, h);
    hold(4);
    do_reset();

    instr(rand_ir(5'd9), 0, 1'b1, 1'b0, h);
    hold(2);
    do_reset();

    instr(rand_ir(5'd7), TO - 1, 1'b0, 1'b0, h);
    instr(rand_ir(5'd11), 1, 1'b0, 1'b1, h);
    instr(rand_ir(5'd6), 0, 1'b0, 1'b0, h);

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 19);
      if (r < 11)      op = 5'($urandom_range(3, 11));
      else if (r < 14) op = 5'b11010;
      else if (r == 14) op = 5'b11011;
      else             op = 5'($urandom_range(0, 31));
      r = $urandom_range(0, 19);
      if (r == 0)      wt = TO;
      else if (r == 1) wt = TO - 1;
      else             wt = $urandom_range(0, 3);
      instr(rand_ir(op), wt, 1'($urandom_range(0, 5) == 0), 1'b0, h);
      if (h) begin
        hold(2);
        do_reset();
      end
    end

    repeat (3) @(negedge Clock);
    check("queue drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
